// File: rtl/mmix_defs_pkg.sv
// rtl/mmix_defs_pkg.sv - shared MMIX definitions used by the instruction prefetch buffer
package mmix_defs;

    // Memory access size code for a 32-bit tetra.
    localparam logic [1:0] DS_TETRA = 2'd2;

    // One prefetched instruction: its address and the tetra fetched from it.
    typedef struct packed {
        logic [63:0] loc;
        logic [31:0] inst;
    } ipf_entry_t;

    localparam int ENTRY_W = $bits(ipf_entry_t);

    typedef enum logic [1:0] {
        IPF_IDLE  = 2'd0,
        IPF_REQ   = 2'd1,
        IPF_DRAIN = 2'd2
    } ipf_state_t;

endpackage

// File: rtl/ipf_fifo.sv
// rtl/ipf_fifo.sv - prefetch entry queue with registered head outputs
//   clk, reset_n          : clock, asynchronous active-low reset
//   push, push_data       : enqueue one entry (ignored when full and not popping)
//   pop                   : dequeue the head entry (ignored when empty)
//   flush                 : empty the queue; overrides push and pop
//   head_valid, head_data : registered head of queue (zero when empty)
//   count                 : number of valid entries
module ipf_fifo
    import mmix_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [ENTRY_W-1:0]           push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic                         head_valid,
    output logic [ENTRY_W-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      rd_ptr_n;
    logic [CW-1:0]      count_n;
    logic               do_push;
    logic               do_pop;
    logic [ENTRY_W-1:0] head_n;

    // The head is registered, so its next value is computed from the
    // post-update pointers. When the new head slot is the one being written
    // this cycle, the incoming data is taken directly.
    always_comb begin
        do_pop   = pop && (count != '0);
        do_push  = push && ((count != CW'(DEPTH)) || do_pop);
        rd_ptr_n = do_pop ? rd_ptr + 1'b1 : rd_ptr;
        count_n  = count + CW'(do_push) - CW'(do_pop);
        head_n   = '0;
        if (count_n != '0) begin
            head_n = (do_push && (rd_ptr_n == wr_ptr)) ? push_data : mem[rd_ptr_n];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr     <= rd_ptr_n;
            count      <= count_n;
            head_valid <= (count_n != '0);
            head_data  <= head_n;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/inst_prefetch_buf.sv
// rtl/inst_prefetch_buf.sv - sequential instruction prefetcher feeding a small queue
//   Optional build macro IPF_PERF_EN adds perf_fetches / perf_flushes counters.
//   clk, reset_n                     : clock, asynchronous active-low reset
//   redirect_valid, redirect_addr    : load a new fetch address and flush the queue
//   head_valid, head_loc, head_inst  : registered head entry; head_pop consumes it
//   mem_address, mem_datasize,
//   mem_read, mem_readdata, mem_done : single-outstanding tetra read port
//   perf_fetches, perf_flushes       : saturating event counters (IPF_PERF_EN only)
module inst_prefetch_buf
    import mmix_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_addr,
    output logic        head_valid,
    output logic [63:0] head_loc,
    output logic [31:0] head_inst,
    input  logic        head_pop,
    output logic [63:0] mem_address,
    output logic [1:0]  mem_datasize,
    output logic        mem_read,
    input  logic [63:0] mem_readdata,
    input  logic        mem_done
`ifdef IPF_PERF_EN
    ,
    output logic [31:0] perf_fetches,
    output logic [31:0] perf_flushes
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    ipf_state_t  state, state_n;
    logic [63:0] fetch_pc, fetch_pc_n;
    logic [63:0] addr_n;
    logic        started, started_n;
    logic        fifo_push;
    logic        fifo_flush;
    logic        drop_inflight;
    logic [CW-1:0] fifo_count;
    ipf_entry_t  push_entry;
    ipf_entry_t  head_entry;
    logic        unused_bits;

    assign unused_bits  = ^{redirect_addr[1:0], mem_readdata[63:32]};
    assign mem_datasize = DS_TETRA;
    // The read strobe is held for the whole transaction, including the drain
    // of a read whose data will be thrown away.
    assign mem_read     = (state != IPF_IDLE);
    assign push_entry   = '{loc: fetch_pc, inst: mem_readdata[31:0]};
    assign head_loc     = head_entry.loc;
    assign head_inst    = head_entry.inst;

    always_comb begin
        state_n       = state;
        fetch_pc_n    = fetch_pc;
        started_n     = started;
        addr_n        = mem_address;
        fifo_push     = 1'b0;
        fifo_flush    = 1'b0;
        drop_inflight = 1'b0;

        if (redirect_valid) begin
            fetch_pc_n = {redirect_addr[63:2], 2'b00};
            started_n  = 1'b1;
            fifo_flush = 1'b1;
        end

        unique case (state)
            IPF_IDLE: begin
                if (!redirect_valid && started && (fifo_count < CW'(DEPTH))) begin
                    state_n = IPF_REQ;
                    addr_n  = fetch_pc;
                end
            end
            IPF_REQ: begin
                if (redirect_valid) begin
                    drop_inflight = 1'b1;
                    state_n       = mem_done ? IPF_IDLE : IPF_DRAIN;
                end else if (mem_done) begin
                    fifo_push  = 1'b1;
                    fetch_pc_n = fetch_pc + 64'd4;
                    state_n    = IPF_IDLE;
                end
            end
            IPF_DRAIN: begin
                drop_inflight = redirect_valid;
                if (mem_done) begin
                    state_n = IPF_IDLE;
                end
            end
            default: state_n = IPF_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IPF_IDLE;
            fetch_pc    <= '0;
            started     <= 1'b0;
            mem_address <= '0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            started     <= started_n;
            mem_address <= addr_n;
        end
    end

    ipf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (fifo_push),
        .push_data  (push_entry),
        .pop        (head_pop),
        .flush      (fifo_flush),
        .head_valid (head_valid),
        .head_data  (head_entry),
        .count      (fifo_count)
    );

`ifdef IPF_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetches <= '0;
            perf_flushes <= '0;
        end else begin
            if (fifo_push && (perf_fetches != '1)) begin
                perf_fetches <= perf_fetches + 32'd1;
            end
            if (drop_inflight && (perf_flushes != '1)) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// tb/tb_inst_prefetch_buf.sv - directed self-checking bench for inst_prefetch_buf
module tb_inst_prefetch_buf;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic [63:0] redirect_addr;
    logic        head_valid;
    logic [63:0] head_loc;
    logic [31:0] head_inst;
    logic        head_pop;
    logic [63:0] mem_address;
    logic [1:0]  mem_datasize;
    logic        mem_read;
    logic [63:0] mem_readdata;
    logic        mem_done;
`ifdef IPF_PERF_EN
    logic [31:0] perf_fetches;
    logic [31:0] perf_flushes;
`endif

    int          total = 0;
    int          passed = 0;
    int          failed = 0;
    logic [63:0] rd_log[$];
    bit          in_flight;
    bit          last_done;
    int          wait_cnt;
    logic [63:0] held_addr;
    logic [63:0] exp_loc;
    int          pops;

    always #5 clk = ~clk;

    inst_prefetch_buf #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .head_valid     (head_valid),
        .head_loc       (head_loc),
        .head_inst      (head_inst),
        .head_pop       (head_pop),
        .mem_address    (mem_address),
        .mem_datasize   (mem_datasize),
        .mem_read       (mem_read),
        .mem_readdata   (mem_readdata),
        .mem_done       (mem_done)
`ifdef IPF_PERF_EN
        ,
        .perf_fetches   (perf_fetches),
        .perf_flushes   (perf_flushes)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        head_pop       = 1'b0;
        mem_done       = 1'b0;
        mem_readdata   = '0;
        step();
        step();
        reset_n = 1'b1;
        step();
        in_flight = 0;
        last_done = 0;
        pops      = 0;
        rd_log.delete();
    endtask

    task automatic redirect(input logic [63:0] a);
        mem_done       = 1'b0;
        head_pop       = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = a;
        step();
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        exp_loc        = {a[63:2], 2'b00};
    endtask

    task automatic wait_read(input int max, input string tag);
        int n = 0;
        while (!mem_read && n < max) begin
            step();
            n++;
        end
        chk(tag, {63'd0, mem_read}, 64'd1);
    endtask

    // One cycle of a memory that answers after lat cycles of mem_read, plus
    // an optional consumer that pops whenever the head is valid.
    task automatic cycle_mem(input int lat, input bit pop_en);
        if (last_done) chk("gap_after_done", {63'd0, mem_read}, 64'd0);
        last_done = 0;
        if (mem_read) begin
            if (!in_flight) begin
                in_flight = 1;
                wait_cnt  = 0;
                held_addr = mem_address;
                rd_log.push_back(mem_address);
            end else begin
                chk("addr_stable", mem_address, held_addr);
            end
            wait_cnt++;
            if (wait_cnt >= lat) begin
                mem_done     = 1'b1;
                mem_readdata = {32'hFFFF_FFFF, mem_word(mem_address)};
                in_flight    = 0;
                last_done    = 1;
            end
        end
        if (pop_en && head_valid) begin
            chk("pop_loc", head_loc, exp_loc);
            chk("pop_inst", {32'd0, head_inst}, {32'd0, mem_word(exp_loc)});
            exp_loc  = exp_loc + 64'd4;
            pops++;
            head_pop = 1'b1;
        end
        step();
        mem_done = 1'b0;
        head_pop = 1'b0;
    endtask

    initial begin
        // Reset values and no fetch before the first redirect.
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        head_pop       = 1'b0;
        mem_done       = 1'b0;
        mem_readdata   = '0;
        step();
        chk("rst_mem_read", {63'd0, mem_read}, 64'd0);
        chk("rst_mem_address", mem_address, 64'd0);
        chk("rst_datasize", {62'd0, mem_datasize}, 64'd2);
        chk("rst_head_valid", {63'd0, head_valid}, 64'd0);
        chk("rst_head_loc", head_loc, 64'd0);
        chk("rst_head_inst", {32'd0, head_inst}, 64'd0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("no_read_before_redirect", {63'd0, mem_read}, 64'd0);
            step();
        end

        // Fill to capacity with a 1-cycle memory, then stall.
        redirect(64'h8000_0000_0000_0003);
        repeat (20) cycle_mem(1, 0);
        chk("fill_read_count", 64'(rd_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
            chk("fill_read_addr", rd_log[i], 64'h8000_0000_0000_0000 + 64'(4 * i));
        end
        chk("fill_head_valid", {63'd0, head_valid}, 64'd1);
        chk("fill_count", 64'(dut.fifo_count), 64'd4);
        chk("fill_stalled", {63'd0, mem_read}, 64'd0);
        chk("fill_head_loc", head_loc, 64'h8000_0000_0000_0000);
        chk("fill_head_inst", {32'd0, head_inst}, {32'd0, mem_word(64'h8000_0000_0000_0000)});

        // Streaming: pop every cycle with latency-3 memory.
        do_reset();
        redirect(64'h1000);
        repeat (60) cycle_mem(3, 1);
        chk("stream_pops", {63'd0, pops >= 10}, 64'd1);
        for (int i = 0; i < rd_log.size(); i++) begin
            chk("stream_read_addr", rd_log[i], 64'h1000 + 64'(4 * i));
        end

        // Redirect while a read to 0x20 is pending.
        do_reset();
        redirect(64'h20);
        step();
        chk("pend_read", {63'd0, mem_read}, 64'd1);
        chk("pend_addr", mem_address, 64'h20);
        redirect_valid = 1'b1;
        redirect_addr  = 64'h100;
        step();
        redirect_valid = 1'b0;
        chk("drain_read", {63'd0, mem_read}, 64'd1);
        chk("drain_addr", mem_address, 64'h20);
        step();
        chk("drain_addr_held", mem_address, 64'h20);
        mem_done     = 1'b1;
        mem_readdata = 64'h0000_0000_DEAD_BEEF;
        step();
        mem_done = 1'b0;
        chk("drain_end_read", {63'd0, mem_read}, 64'd0);
        chk("drain_discarded", {63'd0, head_valid}, 64'd0);
        step();
        chk("after_drain_read", {63'd0, mem_read}, 64'd1);
        chk("after_drain_addr", mem_address, 64'h100);
        mem_done     = 1'b1;
        mem_readdata = {32'd0, mem_word(64'h100)};
        step();
        mem_done = 1'b0;
        chk("redir_head_valid", {63'd0, head_valid}, 64'd1);
        chk("redir_head_loc", head_loc, 64'h100);
        chk("redir_head_inst", {32'd0, head_inst}, {32'd0, mem_word(64'h100)});

        // Redirect, mem_done and head_pop all in one cycle.
        step();
        chk("coinc_req_addr", mem_address, 64'h104);
        chk("coinc_req_read", {63'd0, mem_read}, 64'd1);
        redirect_valid = 1'b1;
        redirect_addr  = 64'h200;
        mem_done       = 1'b1;
        mem_readdata   = 64'h0000_0000_1234_5678;
        head_pop       = 1'b1;
        step();
        redirect_valid = 1'b0;
        mem_done       = 1'b0;
        head_pop       = 1'b0;
        chk("coinc_empty", {63'd0, head_valid}, 64'd0);
        chk("coinc_count", 64'(dut.fifo_count), 64'd0);
        chk("coinc_idle", {63'd0, mem_read}, 64'd0);
        step();
        chk("coinc_next_addr", mem_address, 64'h200);
        chk("coinc_still_empty", {63'd0, head_valid}, 64'd0);
        mem_done     = 1'b1;
        mem_readdata = {32'd0, mem_word(64'h200)};
        step();
        mem_done = 1'b0;
        chk("coinc_head_loc", head_loc, 64'h200);
        chk("coinc_head_inst", {32'd0, head_inst}, {32'd0, mem_word(64'h200)});

        // fetch_pc wraps from the top of the address space to zero.
        do_reset();
        redirect(64'hFFFF_FFFF_FFFF_FFFF);
        repeat (12) cycle_mem(1, 1);
        chk("wrap_read_count", {63'd0, rd_log.size() >= 3}, 64'd1);
        if (rd_log.size() >= 3) begin
            chk("wrap_first", rd_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
            chk("wrap_zero", rd_log[1], 64'h0);
            chk("wrap_four", rd_log[2], 64'h4);
        end

        // Asynchronous reset in the middle of a read.
        do_reset();
        redirect(64'h300);
        repeat (4) cycle_mem(1, 0);
        wait_read(10, "midreq_wait");
        chk("midreq_head_valid", {63'd0, head_valid}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_mem_read", {63'd0, mem_read}, 64'd0);
        chk("arst_mem_address", mem_address, 64'd0);
        chk("arst_head_valid", {63'd0, head_valid}, 64'd0);
        chk("arst_head_loc", head_loc, 64'd0);
        chk("arst_head_inst", {32'd0, head_inst}, 64'd0);
        chk("arst_datasize", {62'd0, mem_datasize}, 64'd2);
        step();
        reset_n  = 1'b1;
        mem_done = 1'b1;
        mem_readdata = 64'h0000_0000_AAAA_5555;
        step();
        mem_done = 1'b0;
        chk("stray_done_ignored", {63'd0, head_valid}, 64'd0);
        step();
        chk("no_read_after_reset", {63'd0, mem_read}, 64'd0);

`ifdef IPF_PERF_EN
        // Three completed fetches and one flushed read.
        do_reset();
        chk("perf_rst_fetches", {32'd0, perf_fetches}, 64'd0);
        chk("perf_rst_flushes", {32'd0, perf_flushes}, 64'd0);
        redirect(64'h40);
        for (int k = 0; k < 3; k++) begin
            wait_read(10, "perf_wait");
            mem_done     = 1'b1;
            mem_readdata = {32'd0, mem_word(mem_address)};
            step();
            mem_done = 1'b0;
        end
        wait_read(10, "perf_wait_flush");
        redirect_valid = 1'b1;
        redirect_addr  = 64'h80;
        step();
        redirect_valid = 1'b0;
        mem_done       = 1'b1;
        step();
        mem_done = 1'b0;
        chk("perf_fetches", {32'd0, perf_fetches}, 64'd3);
        chk("perf_flushes", {32'd0, perf_flushes}, 64'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
